// File: rtl/alu_muldiv_iter_if.sv
// alu_muldiv_iter_if: issue/result bundle between the pipeline (master) and the mul/div unit (slave)
interface alu_muldiv_iter_if #(parameter int WIDTH = 32);
   logic             start_i, cancel_i, stall_o, busy_o, done_o;
   logic [5:0]       op_i;
   logic [WIDTH-1:0] src1_i, src2_i, hi_o, lo_o;
   modport master (output start_i, op_i, src1_i, src2_i, cancel_i,
                   input stall_o, busy_o, done_o, hi_o, lo_o);
   modport slave  (input start_i, op_i, src1_i, src2_i, cancel_i,
                   output stall_o, busy_o, done_o, hi_o, lo_o);
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative shift-add multiply / restoring divide with HI/LO; define FAST_MUL_EN for single-cycle multiply
module alu_muldiv_iter #(parameter int WIDTH = 32) (
   input logic clk,
   input logic resetn,
   alu_muldiv_iter_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2;
   logic [1:0]         r_state;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_hi, r_lo, r_acc, r_q, r_a, r_b, r_raw;
   logic               r_done, r_neg_q, r_neg_r, r_dz;
   logic               w_onehot, w_idle, w_acc, w_iter, w_mul_op, w_sgn, w_s1, w_s2, w_mul;
   logic [WIDTH-1:0]   w_m1, w_m2, w_acc_n, w_q_n, w_hi_n, w_lo_n;
   logic [WIDTH:0]     w_sum, w_trial;
   logic [2*WIDTH-1:0] w_prod, w_prod_s;
   assign w_onehot = (bus.op_i != 6'd0) && ((bus.op_i & (bus.op_i - 6'd1)) == 6'd0);
   assign w_idle   = r_state == S_IDLE;
   assign w_acc    = bus.start_i & ~bus.cancel_i & w_idle & w_onehot;
   assign w_mul_op = bus.op_i[5] | bus.op_i[4];
`ifdef FAST_MUL_EN
   logic [2*WIDTH-1:0] w_fprod, w_fprod_s;
   assign w_iter    = w_acc & (bus.op_i[3] | bus.op_i[2]);
   assign w_fprod   = {{WIDTH{1'b0}}, w_m1} * {{WIDTH{1'b0}}, w_m2};
   assign w_fprod_s = (w_s1 ^ w_s2) ? -w_fprod : w_fprod;
`else
   assign w_iter = w_acc & (|bus.op_i[5:2]);
`endif
   assign w_sgn = bus.op_i[5] | bus.op_i[3];
   assign w_s1  = w_sgn & bus.src1_i[WIDTH-1];
   assign w_s2  = w_sgn & bus.src2_i[WIDTH-1];
   assign w_m1  = w_s1 ? -bus.src1_i : bus.src1_i;
   assign w_m2  = w_s2 ? -bus.src2_i : bus.src2_i;
   assign w_mul = r_state == S_MUL;
   // one iteration step: shift-add for multiply, restoring subtract for divide
   assign w_sum    = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
   assign w_trial  = {r_acc, r_q[WIDTH-1]} - {1'b0, r_b};
   assign w_acc_n  = w_mul ? w_sum[WIDTH:1] : (w_trial[WIDTH] ? {r_acc[WIDTH-2:0], r_q[WIDTH-1]} : w_trial[WIDTH-1:0]);
   assign w_q_n    = w_mul ? {w_sum[0], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
   assign w_prod   = {w_acc_n, w_q_n};
   assign w_prod_s = r_neg_q ? -w_prod : w_prod;
   // a zero divisor overrides the iterated result with all-ones quotient and the raw dividend
   assign w_hi_n = w_mul ? w_prod_s[2*WIDTH-1:WIDTH] : r_dz ? r_raw : r_neg_r ? -w_acc_n : w_acc_n;
   assign w_lo_n = w_mul ? w_prod_s[WIDTH-1:0] : r_dz ? {WIDTH{1'b1}} : r_neg_q ? -w_q_n : w_q_n;
   assign bus.busy_o  = ~w_idle;
   assign bus.stall_o = ~w_idle | w_iter;
   assign bus.done_o  = r_done;
   assign bus.hi_o    = r_hi;
   assign bus.lo_o    = r_lo;
   // accept/iterate/commit state machine; cancel drops the operation without touching HI/LO
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
         r_acc   <= '0;
         r_q     <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_raw   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (!w_idle) begin
            if (bus.cancel_i) begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end else begin
               r_acc <= w_acc_n;
               r_q   <= w_q_n;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH-1)) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_hi    <= w_hi_n;
                  r_lo    <= w_lo_n;
                  r_done  <= 1'b1;
               end
            end
         end else if (w_acc) begin
            if (bus.op_i[1]) r_hi <= bus.src1_i;
            if (bus.op_i[0]) r_lo <= bus.src1_i;
`ifdef FAST_MUL_EN
            if (w_mul_op) begin
               r_hi   <= w_fprod_s[2*WIDTH-1:WIDTH];
               r_lo   <= w_fprod_s[WIDTH-1:0];
               r_done <= 1'b1;
            end
`endif
            if (w_iter) begin
               r_state <= w_mul_op ? S_MUL : S_DIV;
               r_cnt   <= '0;
               r_acc   <= '0;
               r_q     <= w_mul_op ? w_m2 : w_m1;
               r_a     <= w_m1;
               r_b     <= w_m2;
               r_raw   <= bus.src1_i;
               r_dz    <= bus.src2_i == '0;
               r_neg_q <= w_s1 ^ w_s2;
               r_neg_r <= w_s1;
            end
         end
      end
   end
endmodule
